// File: rtl/jtcontra_rom_arb_if.sv
// rtl/jtcontra_rom_arb_if.sv - client and SDRAM-side signal bundle for jtcontra_rom_arb
interface jtcontra_rom_arb_if #(
  parameter int CH = 2,
  parameter int AW = 18,
  parameter int DW = 16
);
  logic [CH-1:0]    ch_en;
  logic [CH-1:0]    ch_cs;
  logic [CH*AW-1:0] ch_addr;
  logic [CH-1:0]    ch_ok;
  logic [CH*DW-1:0] ch_data;
  logic             rom_cs;
  logic [AW-1:0]    rom_addr;
  logic [DW-1:0]    rom_data;
  logic             rom_ok;
  logic             busy;
  logic             err;

  modport master (
    output ch_en, ch_cs, ch_addr, rom_data, rom_ok,
    input  ch_ok, ch_data, rom_cs, rom_addr, busy, err
  );

  modport slave (
    input  ch_en, ch_cs, ch_addr, rom_data, rom_ok,
    output ch_ok, ch_data, rom_cs, rom_addr, busy, err
  );
endinterface

// File: rtl/jtcontra_rom_arb.sv
// rtl/jtcontra_rom_arb.sv - fixed/round-robin SDRAM arbiter for graphics ROM clients
// Optional WAIT timeout with err pulse: define JTCONTRA_ROMARB_TIMEOUT_EN.
module jtcontra_rom_arb #(
  parameter int CH = 2,
  parameter int AW = 18,
  parameter int DW = 16,
  parameter int RR = 0
) (
  input  logic              clk,
  input  logic              rst,
  jtcontra_rom_arb_if.slave bus
);
  localparam int GW = $clog2(CH);

  typedef enum logic [1:0] {IDLE, GUARD, WAIT} state_t;

  state_t        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_q;
  logic [GW-1:0] grant_d;
  logic [GW-1:0] lo_idx;
  logic [GW-1:0] hi_idx;
  logic          hi_vld;
  logic [CH-1:0] ch_ok_q;
  logic [CH-1:0] pend;
  logic [DW-1:0] data_q      [CH];
  logic [AW-1:0] last_addr_q [CH];
  logic [AW-1:0] addr_w      [CH];
  logic          rom_cs_q;
  logic [AW-1:0] rom_addr_q;
  logic          timeout;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    assign addr_w[i]                = bus.ch_addr[i*AW +: AW];
    assign bus.ch_data[i*DW +: DW]  = data_q[i];
  end

  assign pend         = bus.ch_cs & bus.ch_en & ~ch_ok_q;
  assign bus.ch_ok    = ch_ok_q;
  assign bus.rom_cs   = rom_cs_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.busy     = (state_q != IDLE);

  // lo_idx: lowest pending; hi_idx: lowest pending above the last grant (round-robin wrap)
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_vld = 1'b0;
    for (int i = CH-1; i >= 0; i--) begin
      if (pend[i]) begin
        lo_idx = GW'(i);
        if (i > int'(rr_q)) begin
          hi_idx = GW'(i);
          hi_vld = 1'b1;
        end
      end
    end
    grant_d = (RR != 0 && hi_vld) ? hi_idx : lo_idx;
  end

`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
  logic [7:0] timer_q;
  logic       err_q;
  assign timeout = &timer_q;
  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= GW'(CH-1);
      ch_ok_q    <= '0;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= '0;
      for (int i = 0; i < CH; i++) begin
        data_q[i]      <= '0;
        last_addr_q[i] <= '0;
      end
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      for (int i = 0; i < CH; i++) begin
        if (!bus.ch_cs[i] || addr_w[i] != last_addr_q[i]) ch_ok_q[i] <= 1'b0;
        if (bus.ch_cs[i] && !bus.ch_en[i]) begin
          ch_ok_q[i] <= 1'b1;
          data_q[i]  <= '0;
        end
      end
      case (state_q)
        IDLE: begin
          if (|pend) begin
            rom_cs_q             <= 1'b1;
            rom_addr_q           <= addr_w[grant_d];
            last_addr_q[grant_d] <= addr_w[grant_d];
            grant_q              <= grant_d;
            rr_q                 <= grant_d;
            state_q              <= GUARD;
          end else begin
            rom_cs_q <= 1'b0;
          end
        end
        // rom_ok here may still belong to the previous slot
        GUARD: begin
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
          timer_q <= 8'd1;
`endif
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.rom_ok || timeout) begin
            data_q[grant_q] <= bus.rom_ok ? bus.rom_data : {DW{1'b1}};
            if (bus.ch_cs[grant_q] && addr_w[grant_q] == last_addr_q[grant_q])
              ch_ok_q[grant_q] <= 1'b1;
            rom_cs_q <= 1'b0;
            state_q  <= IDLE;
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
            err_q <= !bus.rom_ok;
`endif
          end else begin
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
            timer_q <= timer_q + 8'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jtcontra_rom_arb.sv
// tb/tb_jtcontra_rom_arb.sv - randomized self-checking bench for jtcontra_rom_arb
module tb_jtcontra_rom_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  jtcontra_rom_arb_if #(.CH(2), .AW(18), .DW(16)) ba ();
  jtcontra_rom_arb_if #(.CH(4), .AW(18), .DW(16)) bb ();

  jtcontra_rom_arb #(.CH(2), .AW(18), .DW(16), .RR(0)) dut_a (.clk(clk), .rst(rst), .bus(ba));
  jtcontra_rom_arb #(.CH(4), .AW(18), .DW(16), .RR(1)) dut_b (.clk(clk), .rst(rst), .bus(bb));

  int   rises_a = 0;
  logic prev_a  = 1'b0;
  always @(posedge clk) begin
    if (ba.rom_cs && !prev_a) rises_a++;
    prev_a = ba.rom_cs;
  end

  int rr_last = 3;
  int order_b[$];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cs_a(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (ba.rom_cs) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_cs_b(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (bb.rom_cs) begin ok = 1'b1; break; end
    end
  endtask

  task automatic respond_a(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    ba.rom_data = d;
    ba.rom_ok   = 1'b1;
    tick();
    ba.rom_ok   = 1'b0;
  endtask

  task automatic respond_b(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    bb.rom_data = d;
    bb.rom_ok   = 1'b1;
    tick();
    bb.rom_ok   = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] m, input int last);
    int r;
    r = -1;
    for (int k = 4; k >= 1; k--) if (((m >> ((last + k) % 4)) & 4'd1) != 0) r = (last + k) % 4;
    return r;
  endfunction

  task automatic test_reset();
    ba.ch_en = 2'b11; ba.ch_cs = '0; ba.ch_addr = '0; ba.rom_data = '0; ba.rom_ok = 1'b0;
    bb.ch_en = 4'hF;  bb.ch_cs = '0; bb.ch_addr = '0; bb.rom_data = '0; bb.rom_ok = 1'b0;
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({ba.rom_cs, ba.rom_addr, ba.ch_ok, ba.ch_data, ba.busy, ba.err} !== '0) begin
      errors++;
      $display("FAIL reset_a got cs=%b addr=%h ok=%b data=%h busy=%b err=%b exp all 0",
               ba.rom_cs, ba.rom_addr, ba.ch_ok, ba.ch_data, ba.busy, ba.err);
    end
    checks++;
    if ({bb.rom_cs, bb.rom_addr, bb.ch_ok, bb.ch_data, bb.busy, bb.err} !== '0) begin
      errors++;
      $display("FAIL reset_b got cs=%b addr=%h ok=%b data=%h busy=%b exp all 0",
               bb.rom_cs, bb.rom_addr, bb.ch_ok, bb.ch_data, bb.busy);
    end
    rst = 1'b0;
    rr_last = 3;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    int r0;
    r0 = rises_a;
    ba.ch_addr[17:0] = 18'h12345;
    ba.ch_cs = 2'b01;
    wait_cs_a(ok);
    checks++;
    if (!ok || ba.rom_addr !== 18'h12345 || ba.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_req got ok=%0d addr=%h busy=%b exp addr=12345 busy=1", ok, ba.rom_addr, ba.busy);
    end
    respond_a(3, 16'hBEEF);
    checks++;
    if (ba.ch_ok !== 2'b01 || ba.ch_data[15:0] !== 16'hBEEF || ba.rom_cs !== 1'b0 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got ok=%b data=%h cs=%b busy=%b exp ok=01 data=beef cs=0 busy=0",
               ba.ch_ok, ba.ch_data[15:0], ba.rom_cs, ba.busy);
    end
    repeat (8) tick();
    checks++;
    if (rises_a - r0 != 1) begin
      errors++;
      $display("FAIL single_pulses got %0d exp 1", rises_a - r0);
    end
    ba.ch_cs = '0;
    tick();
    checks++;
    if (ba.ch_ok !== 2'b00) begin
      errors++;
      $display("FAIL single_cs_drop got ok=%b exp 00", ba.ch_ok);
    end
  endtask

  task automatic round_a(input logic [1:0] mask);
    logic [35:0] addrs;
    logic [15:0] d;
    logic [1:0]  left;
    logic [1:0]  exp_ok;
    int g;
    bit ok;
    left   = mask;
    exp_ok = '0;
    addrs  = {18'($urandom), 18'($urandom)};
    ba.ch_addr = addrs;
    ba.ch_cs   = mask;
    while (left != 0) begin
      g = left[0] ? 0 : 1;
      wait_cs_a(ok);
      checks++;
      if (!ok || ba.rom_addr !== 18'(addrs >> (g*18))) begin
        errors++;
        $display("FAIL fixed_grant got ok=%0d addr=%h exp addr=%h (client %0d)", ok, ba.rom_addr, 18'(addrs >> (g*18)), g);
      end
      d = 16'($urandom);
      respond_a($urandom_range(1, 4), d);
      exp_ok = exp_ok | (2'b01 << g);
      left   = left & ~(2'b01 << g);
      checks++;
      if (ba.ch_ok !== exp_ok || 16'(ba.ch_data >> (g*16)) !== d) begin
        errors++;
        $display("FAIL fixed_data got ok=%b data=%h exp ok=%b data=%h", ba.ch_ok, 16'(ba.ch_data >> (g*16)), exp_ok, d);
      end
    end
    ba.ch_cs = '0;
    tick();
  endtask

  task automatic test_fixed_priority();
    round_a(2'b11);
    for (int r = 0; r < 6; r++) round_a(2'($urandom_range(1, 3)));
  endtask

  task automatic round_b(input logic [3:0] mask);
    logic [71:0] addrs;
    logic [15:0] d;
    logic [3:0]  left;
    logic [3:0]  exp_ok;
    int g;
    bit ok;
    left   = mask;
    exp_ok = '0;
    addrs  = {18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom)};
    bb.ch_addr = addrs;
    bb.ch_cs   = mask;
    while (left != 0) begin
      g = rr_pick(left, rr_last);
      wait_cs_b(ok);
      order_b.push_back(g);
      checks++;
      if (!ok || bb.rom_addr !== 18'(addrs >> (g*18))) begin
        errors++;
        $display("FAIL rr_grant got ok=%0d addr=%h exp addr=%h (client %0d)", ok, bb.rom_addr, 18'(addrs >> (g*18)), g);
      end
      d = 16'($urandom);
      respond_b($urandom_range(1, 3), d);
      rr_last = g;
      exp_ok  = exp_ok | (4'b0001 << g);
      left    = left & ~(4'b0001 << g);
      checks++;
      if (bb.ch_ok !== exp_ok || 16'(bb.ch_data >> (g*16)) !== d) begin
        errors++;
        $display("FAIL rr_data got ok=%b data=%h exp ok=%b data=%h", bb.ch_ok, 16'(bb.ch_data >> (g*16)), exp_ok, d);
      end
    end
    bb.ch_cs = '0;
    tick();
  endtask

  task automatic test_round_robin();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    order_b.delete();
    round_b(4'hF);
    round_b(4'hF);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (order_b.size() <= i || order_b[i] != exp_order[i]) begin
        errors++;
        $display("FAIL rr_order[%0d] got %0d exp %0d", i, (order_b.size() > i) ? order_b[i] : -1, exp_order[i]);
      end
    end
    for (int r = 0; r < 6; r++) round_b(4'($urandom_range(1, 15)));
  endtask

  task automatic test_addr_change();
    bit ok;
    logic [15:0] d1, d2;
    d1 = 16'($urandom);
    d2 = ~d1;
    ba.ch_addr[35:18] = 18'h00100;
    ba.ch_cs = 2'b10;
    wait_cs_a(ok);
    respond_a(2, d1);
    checks++;
    if (ba.ch_ok !== 2'b10 || ba.ch_data[31:16] !== d1) begin
      errors++;
      $display("FAIL addr_first got ok=%b data=%h exp ok=10 data=%h", ba.ch_ok, ba.ch_data[31:16], d1);
    end
    ba.ch_addr[35:18] = 18'h00104;
    tick();
    checks++;
    if (ba.ch_ok !== 2'b00) begin
      errors++;
      $display("FAIL addr_clear got ok=%b exp 00", ba.ch_ok);
    end
    wait_cs_a(ok);
    checks++;
    if (!ok || ba.rom_addr !== 18'h00104) begin
      errors++;
      $display("FAIL addr_reissue got ok=%0d addr=%h exp 00104", ok, ba.rom_addr);
    end
    respond_a(1, d2);
    checks++;
    if (ba.ch_ok !== 2'b10 || ba.ch_data[31:16] !== d2) begin
      errors++;
      $display("FAIL addr_second got ok=%b data=%h exp ok=10 data=%h", ba.ch_ok, ba.ch_data[31:16], d2);
    end
    ba.ch_cs = '0;
    tick();
  endtask

  task automatic test_discard();
    bit ok;
    ba.ch_addr[17:0] = 18'($urandom);
    ba.ch_cs = 2'b01;
    wait_cs_a(ok);
    ba.ch_cs = 2'b00;
    respond_a(1, 16'h5A5A);
    checks++;
    if (ba.ch_ok !== 2'b00 || ba.busy !== 1'b0) begin
      errors++;
      $display("FAIL discard got ok=%b busy=%b exp ok=00 busy=0", ba.ch_ok, ba.busy);
    end
    tick();
  endtask

  task automatic test_disabled();
    int r0;
    r0 = rises_a;
    ba.ch_en = 2'b10;
    ba.ch_cs = 2'b01;
    tick();
    checks++;
    if (ba.ch_ok !== 2'b01 || ba.ch_data[15:0] !== 16'h0000) begin
      errors++;
      $display("FAIL disabled_ok got ok=%b data=%h exp ok=01 data=0000", ba.ch_ok, ba.ch_data[15:0]);
    end
    repeat (5) tick();
    checks++;
    if (rises_a != r0 || ba.rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL disabled_nocs got pulses=%0d cs=%b exp 0 0", rises_a - r0, ba.rom_cs);
    end
    ba.ch_cs = '0;
    ba.ch_en = 2'b11;
    tick();
  endtask

  task automatic test_ok_held();
    logic [15:0] da, db;
    da = 16'($urandom);
    db = ~da;
    ba.ch_addr[35:18] = 18'($urandom);
    ba.rom_data = 16'h1111;
    ba.rom_ok   = 1'b1;
    ba.ch_cs    = 2'b10;
    tick();
    checks++;
    if (ba.rom_cs !== 1'b1 || ba.ch_ok !== 2'b00) begin
      errors++;
      $display("FAIL held_idle got cs=%b ok=%b exp cs=1 ok=00", ba.rom_cs, ba.ch_ok);
    end
    ba.rom_data = da;
    tick();
    checks++;
    if (ba.ch_ok !== 2'b00) begin
      errors++;
      $display("FAIL held_guard got ok=%b exp 00", ba.ch_ok);
    end
    ba.rom_data = db;
    tick();
    checks++;
    if (ba.ch_ok !== 2'b10 || ba.ch_data[31:16] !== db || ba.rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL held_wait got ok=%b data=%h cs=%b exp ok=10 data=%h cs=0", ba.ch_ok, ba.ch_data[31:16], ba.rom_cs, db);
    end
    ba.rom_ok = 1'b0;
    ba.ch_cs  = '0;
    tick();
  endtask

  task automatic test_hang();
    bit ok;
    int c;
    bit saw_err;
    ba.ch_addr[17:0] = 18'($urandom);
    ba.ch_cs = 2'b01;
    wait_cs_a(ok);
`ifdef JTCONTRA_ROMARB_TIMEOUT_EN
    c = 0;
    saw_err = 1'b0;
    while (c < 400 && !saw_err) begin
      tick();
      c++;
      saw_err = ba.err;
    end
    checks++;
    if (c != 256) begin
      errors++;
      $display("FAIL timeout_cycles got %0d exp 256", c);
    end
    checks++;
    if (ba.ch_data[15:0] !== 16'hFFFF || ba.ch_ok !== 2'b01 || ba.busy !== 1'b0 || ba.rom_cs !== 1'b0) begin
      errors++;
      $display("FAIL timeout_done got data=%h ok=%b busy=%b cs=%b exp ffff 01 0 0",
               ba.ch_data[15:0], ba.ch_ok, ba.busy, ba.rom_cs);
    end
    tick();
    checks++;
    if (ba.err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got err=%b exp 0", ba.err);
    end
`else
    saw_err = 1'b0;
    for (c = 0; c < 300; c++) begin
      tick();
      if (ba.err !== 1'b0) saw_err = 1'b1;
    end
    checks++;
    if (saw_err || ba.busy !== 1'b1 || ba.ch_ok !== 2'b00 || ba.rom_cs !== 1'b1) begin
      errors++;
      $display("FAIL hang got err_seen=%0d busy=%b ok=%b cs=%b exp 0 1 00 1", saw_err, ba.busy, ba.ch_ok, ba.rom_cs);
    end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    ba.ch_cs = 2'b00;
    tick();
    if (!ba.busy) begin
      ba.ch_addr[35:18] = 18'($urandom);
      ba.ch_cs = 2'b10;
      wait_cs_a(ok);
    end
    ba.rom_data = 16'($urandom);
    ba.rom_ok   = 1'b1;
    rst = 1'b1;
    #2;
    checks++;
    if ({ba.rom_cs, ba.rom_addr, ba.ch_ok, ba.ch_data, ba.busy, ba.err} !== '0) begin
      errors++;
      $display("FAIL reset_async got cs=%b addr=%h ok=%b data=%h busy=%b err=%b exp all 0",
               ba.rom_cs, ba.rom_addr, ba.ch_ok, ba.ch_data, ba.busy, ba.err);
    end
    tick();
    rst = 1'b0;
    ba.rom_ok = 1'b0;
    ba.ch_cs  = '0;
    rr_last   = 3;
    tick();
    checks++;
    if ({ba.rom_cs, ba.ch_ok, ba.ch_data, ba.busy} !== '0) begin
      errors++;
      $display("FAIL reset_after got cs=%b ok=%b data=%h busy=%b exp all 0", ba.rom_cs, ba.ch_ok, ba.ch_data, ba.busy);
    end
    order_b.delete();
    round_b(4'b1010);
    checks++;
    if (order_b.size() < 1 || order_b[0] != 1) begin
      errors++;
      $display("FAIL reset_rr got first=%0d exp 1", (order_b.size() > 0) ? order_b[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_priority();
    test_round_robin();
    test_addr_change();
    test_discard();
    test_disabled();
    test_ok_held();
    test_hang();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jtcontra_rom_arb.md
# jtcontra_rom_arb

Parametrised SDRAM request arbiter for the graphics chip. It sits between CH graphics clients (tilemap, objects, and later extra layers) and a single SDRAM slot. Clients hold a chip-select and an address. The arbiter grants one client at a time, with either fixed or round-robin priority, and returns latched data plus a per-client `ok`. A client is re-served automatically when its address changes while its chip-select stays asserted.

## Interface
Parameters:
- CH, 2: number of clients (2..8)
- AW, 18: address width
- DW, 16: data width
- RR, 0: 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- ch_en  in  CH  per-client enable (debug layer mask)
- ch_cs  in  CH  per-client request
- ch_addr  in  CH*AW  client addresses, client i at [i*AW +: AW]
- ch_ok  out  CH  client data valid
- ch_data  out  CH*DW  per-client latched data
- rom_cs  out  1  SDRAM request
- rom_addr  out  AW  SDRAM address
- rom_data  in  DW  SDRAM data
- rom_ok  in  1  SDRAM data valid
- busy  out  1  transaction in progress (state != IDLE)
- err  out  1  one-cycle pulse on timeout (only with the timeout macro, else tied 0)

## Operation
- Each client has a stored last-served address `last_addr[i]`.
- Client i is pending when `ch_cs[i] & ch_en[i] & ~ch_ok[i]`.
- `ch_ok[i]` clears, in any state, when `ch_cs[i]` is low or `ch_addr[i] != last_addr[i]`.
- Disabled client: `ch_cs[i] & ~ch_en[i]` forces `ch_data[i]=0` and `ch_ok[i]=1` on the next clock. It never requests SDRAM.
- State machine:
  - IDLE: if any client is pending, select grant g. In fixed mode this is the lowest pending index. In RR mode it is the first pending index after the last grant, wrapping CH-1 -> 0. Register `rom_addr <= ch_addr[g]`, `rom_cs <= 1`, `last_addr[g] <= ch_addr[g]`, then go to GUARD. Otherwise `rom_cs <= 0`.
  - GUARD: one cycle in which `rom_ok` is ignored, because it may be stale from the previous slot. Go to WAIT.
  - WAIT: on `rom_ok`, `ch_data[g] <= rom_data`. Set `ch_ok[g] <= 1` only if `ch_cs[g]` is still high and `ch_addr[g]==last_addr[g]`; otherwise discard the data. Set `rom_cs <= 0` and go to IDLE.
- `rom_addr` is held stable from GUARD until IDLE.
- A grant-side `ch_ok` set takes priority over the address-compare clear in the same cycle only when the addresses match.

## Timing
- Reset values: `rom_cs=0`, `rom_addr=0`, `ch_ok=0`, `ch_data=0`, `busy=0`, `err=0`. State is IDLE, RR pointer is CH-1 (so client 0 wins first), `last_addr` is all 0.
- Pending seen at edge n: `rom_cs` and `rom_addr` valid after n, state WAIT after n+1. The earliest `rom_ok` accepted is at edge n+2, and `ch_ok` is high after n+2.
- `rom_cs` drops for at least one cycle (IDLE) between consecutive transactions.
- An address change on a served client: `ch_ok` falls the next cycle; the client is pending again.
- Reset asserted mid-transaction: immediate return to reset values; the in-flight `rom_ok` is ignored.
- `rom_ok` in IDLE or GUARD has no effect.

## Configuration
- JTCONTRA_ROMARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - After 255 cycles without `rom_ok`, the arbiter sets `ch_data[g]` to all ones and `ch_ok[g]=1` (same cs/address qualification as a normal completion).
  - It also pulses `err` for one cycle, drops `rom_cs`, and returns to IDLE.
- Undefined: WAIT lasts indefinitely and `err` is constant 0.

## Test plan
- Single client, CH=2, client 0 `cs=1` at addr 0x12345, SDRAM returns 0xBEEF 3 cycles after `rom_cs` -> `rom_addr=0x12345`; `ch_ok[0]=1` and `ch_data[0]=0xBEEF`; exactly one `rom_cs` pulse while cs is held.
- Both clients pending simultaneously, RR=0 -> client 0 served first, then client 1. With RR=1 and CH=4, all four pending, repeated requests -> grant order 0,1,2,3,0.
- Client 1 holds cs and changes addr 0x100 -> 0x104 after ok -> `ch_ok[1]` low the next cycle, new transaction at 0x104, ok returns.
- `ch_en[0]=0`, `cs[0]=1` -> `ch_ok[0]=1` and `ch_data[0]=0` next cycle; `rom_cs` never issued for client 0.
- `rom_ok` held high continuously -> the GUARD cycle is respected; data is latched at the WAIT edge, not at the GUARD edge.
- With the macro defined and `rom_ok` never asserted -> after 255 WAIT cycles, `err` pulses, `ch_data=0xFFFF`, `ch_ok=1`, `busy=0`; a reset pulse mid-WAIT clears all outputs.
